// File: rtl/fan_cfg_loader.sv
// Framed byte-stream loader: PID coefficients and PWM limits go to shadow registers, then all seven copy to the active outputs together on a pid tick.
// Latency: a shadow register is written on the edge that accepts its last payload byte; the active outputs change 1 clk after the applying tick.
// Backpressure: cfg_ready_o stays low from an accepted commit until the tick that applies it, so the shadow set cannot change meanwhile.
module fan_cfg_loader #(
    parameter int ADC_BITWIDTH   = 8,
    parameter int REG_BITWIDTH   = 32,
    parameter int RST_PERIOD     = 255,
    parameter int RST_MIN        = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [7:0]                     cfg_data_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic                           pid_tick_i,
    output logic signed [REG_BITWIDTH-1:0] a0_o,
    output logic signed [REG_BITWIDTH-1:0] a1_o,
    output logic signed [REG_BITWIDTH-1:0] b0_o,
    output logic signed [REG_BITWIDTH-1:0] b1_o,
    output logic signed [REG_BITWIDTH-1:0] b2_o,
    output logic [ADC_BITWIDTH:0]          pwm_period_o,
    output logic [ADC_BITWIDTH-1:0]        pwm_min_o,
    output logic                           commit_pending_o,
    output logic                           updated_o,
    output logic                           err_o
);
    localparam int PER_W = ADC_BITWIDTH + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] COEF_LEN = 3'(REG_BITWIDTH / 8);

    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     addr_q, addr_d;
    logic [2:0]                     cnt_q, cnt_d;
    logic [23:0]                    asm_q, asm_d;
    logic [TO_W-1:0]                idle_q, idle_d;
    logic signed [REG_BITWIDTH-1:0] sh_coef_q [5];
    logic signed [REG_BITWIDTH-1:0] sh_coef_d [5];
    logic signed [REG_BITWIDTH-1:0] act_coef_q [5];
    logic signed [REG_BITWIDTH-1:0] act_coef_d [5];
    logic [PER_W-1:0]               sh_per_q, sh_per_d, act_per_q, act_per_d;
    logic [ADC_BITWIDTH-1:0]        sh_min_q, sh_min_d, act_min_q, act_min_d;
    logic                           pend_q, pend_d;
    logic                           upd_q, upd_d;
    logic                           err_q, err_d;
    logic                           rdy_q, rdy_d;
    logic                           acc;
    logic [31:0]                    asm_shift;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        idle_d     = idle_q;
        sh_coef_d  = sh_coef_q;
        act_coef_d = act_coef_q;
        sh_per_d   = sh_per_q;
        act_per_d  = act_per_q;
        sh_min_d   = sh_min_q;
        act_min_d  = act_min_q;
        pend_d     = pend_q;
        upd_d      = 1'b0;
        err_d      = err_q;
        acc        = cfg_valid_i & rdy_q;
        asm_shift  = {asm_q, cfg_data_i};

        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (cfg_data_i[7:4] != 4'hA) begin
                        err_d = 1'b1;
                    end else if (cfg_data_i[2:0] == 3'd7) begin
                        pend_d = 1'b1;
                    end else begin
                        addr_d  = cfg_data_i[2:0];
                        cnt_d   = (cfg_data_i[2:0] == 3'd5) ? 3'd2 :
                                  (cfg_data_i[2:0] == 3'd6) ? 3'd1 : COEF_LEN;
                        asm_d   = '0;
                        idle_d  = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            default: begin
                if (acc) begin
                    asm_d  = asm_shift[23:0];
                    cnt_d  = cnt_q - 3'd1;
                    idle_d = '0;
                    if (cnt_q == 3'd1) begin
                        state_d = S_IDLE;
                        if (addr_q == 3'd5) begin
                            sh_per_d = asm_shift[PER_W-1:0];
                        end else if (addr_q == 3'd6) begin
                            sh_min_d = asm_shift[ADC_BITWIDTH-1:0];
                        end else begin
                            for (int i = 0; i < 5; i++) begin
                                if (addr_q == 3'(i)) sh_coef_d[i] = asm_shift[REG_BITWIDTH-1:0];
                            end
                        end
                    end
                end else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Stalled frame: drop it, shadow keeps its old value.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        endcase

        // No frame can be in flight while a commit is pending, so apply never races a shadow write.
        if (pid_tick_i && pend_q) begin
            act_coef_d = sh_coef_q;
            act_per_d  = sh_per_q;
            act_min_d  = sh_min_q;
            pend_d     = 1'b0;
            upd_d      = 1'b1;
            err_d      = 1'b0;
        end

        rdy_d = ~pend_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            idle_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                sh_coef_q[i]  <= '0;
                act_coef_q[i] <= '0;
            end
            sh_per_q  <= PER_W'(RST_PERIOD);
            act_per_q <= PER_W'(RST_PERIOD);
            sh_min_q  <= ADC_BITWIDTH'(RST_MIN);
            act_min_q <= ADC_BITWIDTH'(RST_MIN);
            pend_q    <= 1'b0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            idle_q     <= idle_d;
            sh_coef_q  <= sh_coef_d;
            act_coef_q <= act_coef_d;
            sh_per_q   <= sh_per_d;
            act_per_q  <= act_per_d;
            sh_min_q   <= sh_min_d;
            act_min_q  <= act_min_d;
            pend_q     <= pend_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
        end
    end

    assign cfg_ready_o      = rdy_q;
    assign a0_o             = act_coef_q[0];
    assign a1_o             = act_coef_q[1];
    assign b0_o             = act_coef_q[2];
    assign b1_o             = act_coef_q[3];
    assign b2_o             = act_coef_q[4];
    assign pwm_period_o     = act_per_q;
    assign pwm_min_o        = act_min_q;
    assign commit_pending_o = pend_q;
    assign updated_o        = upd_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_fan_cfg_loader.sv
// Bench for fan_cfg_loader: frame-level reference model checked every cycle, directed scenarios with literal pins, then random traffic.
module tb_fan_cfg_loader;
    localparam int TO = 1000;

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic [7:0]        cfg_data_i = 8'h00;
    logic              cfg_valid_i = 1'b0;
    logic              pid_tick_i = 1'b0;
    logic              cfg_ready_o;
    logic signed [31:0] a0_o, a1_o, b0_o, b1_o, b2_o;
    logic [8:0]        pwm_period_o;
    logic [7:0]        pwm_min_o;
    logic              commit_pending_o, updated_o, err_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    fan_cfg_loader #(
        .ADC_BITWIDTH(8), .REG_BITWIDTH(32), .RST_PERIOD(255), .RST_MIN(0), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o), .pid_tick_i(pid_tick_i),
        .a0_o(a0_o), .a1_o(a1_o), .b0_o(b0_o), .b1_o(b1_o), .b2_o(b2_o),
        .pwm_period_o(pwm_period_o), .pwm_min_o(pwm_min_o),
        .commit_pending_o(commit_pending_o), .updated_o(updated_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: registers indexed 0..4 coefficients, 5 period, 6 min.
    logic [31:0] m_sh [7];
    logic [31:0] m_act [7];
    bit          m_pend, m_upd, m_err, m_rdy, m_inf;
    int          m_addr, m_need, m_gap;
    logic [7:0]  m_bytes [$];

    function automatic int plen(input int a);
        return (a < 5) ? 4 : ((a == 5) ? 2 : 1);
    endfunction

    function automatic logic [31:0] fit_val(input int a, input longint v);
        longint mask;
        mask = (a < 5) ? 64'hFFFF_FFFF : ((a == 5) ? 64'd511 : 64'd255);
        return 32'(v & mask);
    endfunction

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 7; i++) begin
                m_sh[i]  = (i == 5) ? 32'd255 : 32'd0;
                m_act[i] = (i == 5) ? 32'd255 : 32'd0;
            end
            m_pend = 0; m_upd = 0; m_err = 0; m_rdy = 0; m_inf = 0; m_gap = 0;
            m_bytes.delete();
        end else begin
            bit     acc;
            longint v;
            acc   = cfg_valid_i && m_rdy;
            m_upd = 0;
            if (pid_tick_i && m_pend) begin
                m_act  = m_sh;
                m_pend = 0;
                m_upd  = 1;
                m_err  = 0;
            end
            if (acc) begin
                if (!m_inf) begin
                    if (cfg_data_i[7:4] != 4'hA) m_err = 1;
                    else if (cfg_data_i[2:0] == 3'd7) m_pend = 1;
                    else begin
                        m_inf  = 1;
                        m_addr = int'(cfg_data_i[2:0]);
                        m_need = plen(m_addr);
                        m_gap  = 0;
                        m_bytes.delete();
                    end
                end else begin
                    m_bytes.push_back(cfg_data_i);
                    m_gap = 0;
                    if (m_bytes.size() == m_need) begin
                        v = 0;
                        foreach (m_bytes[k]) v = v * 256 + longint'(m_bytes[k]);
                        m_sh[m_addr] = fit_val(m_addr, v);
                        m_inf = 0;
                    end
                end
            end else if (m_inf) begin
                m_gap++;
                if (m_gap == TO) begin
                    m_err = 1;
                    m_inf = 0;
                end
            end
            m_rdy = !m_pend;
        end
    end

    always @(negedge clk_i) begin
        if (!done) begin
            chk("ready", 64'(cfg_ready_o), 64'(m_rdy));
            chk("pending", 64'(commit_pending_o), 64'(m_pend));
            chk("updated", 64'(updated_o), 64'(m_upd));
            chk("err", 64'(err_o), 64'(m_err));
            chk("a0", 64'($unsigned(a0_o)), 64'(m_act[0]));
            chk("a1", 64'($unsigned(a1_o)), 64'(m_act[1]));
            chk("b0", 64'($unsigned(b0_o)), 64'(m_act[2]));
            chk("b1", 64'($unsigned(b1_o)), 64'(m_act[3]));
            chk("b2", 64'($unsigned(b2_o)), 64'(m_act[4]));
            chk("period", 64'(pwm_period_o), 64'(m_act[5]));
            chk("min", 64'(pwm_min_o), 64'(m_act[6]));
        end
    end

    // Drivers assume they start right after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap = 0, input bit tw = 1'b0);
        int n;
        idle(gap);
        cfg_valid_i = 1'b1;
        cfg_data_i  = b;
        n = 0;
        while (!cfg_ready_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_wait: ready stayed %0b, required 1 within 5000 cycles", cfg_ready_o);
        end
        pid_tick_i = tw;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        pid_tick_i  = 1'b0;
    endtask

    task automatic tick();
        pid_tick_i = 1'b1;
        @(negedge clk_i);
        pid_tick_i = 1'b0;
    endtask

    task automatic send_frame(input int a, input logic [31:0] v, input int gap = 0);
        send_byte({4'hA, 1'($urandom_range(0, 1)), 3'(a)}, gap);
        for (int i = plen(a) - 1; i >= 0; i--) send_byte(v[8*i +: 8], gap);
    endtask

    initial begin
        idle(3);
        chk("ready_in_reset", 64'(cfg_ready_o), 64'd0);
        #1 rstn_i = 1'b1;
        idle(1);
        chk("ready_after_reset", 64'(cfg_ready_o), 64'd1);

        // Full load
        send_frame(0, 32'h0000_0010);
        send_frame(4, 32'hC000_0000);
        send_frame(5, 32'h0000_0120);
        send_frame(6, 32'h0000_0030);
        send_byte(8'hA7);
        chk("lit_pend_before_tick", 64'(commit_pending_o), 64'd1);
        chk("lit_a0_before_tick", 64'($unsigned(a0_o)), 64'd0);
        chk("lit_period_before_tick", 64'(pwm_period_o), 64'd255);
        idle(2);
        tick();
        chk("lit_a0", 64'($unsigned(a0_o)), 64'h0000_0010);
        chk("lit_b2", 64'($unsigned(b2_o)), 64'hC000_0000);
        chk("lit_period", 64'(pwm_period_o), 64'h120);
        chk("lit_min", 64'(pwm_min_o), 64'h30);
        chk("lit_updated_hi", 64'(updated_o), 64'd1);
        idle(1);
        chk("lit_updated_lo", 64'(updated_o), 64'd0);

        // Reset in the middle of a payload
        send_byte(8'hA0);
        send_byte(8'h12);
        #1 rstn_i = 1'b0;
        idle(1);
        chk("lit_rst_a0", 64'($unsigned(a0_o)), 64'd0);
        chk("lit_rst_b2", 64'($unsigned(b2_o)), 64'd0);
        chk("lit_rst_period", 64'(pwm_period_o), 64'd255);
        chk("lit_rst_min", 64'(pwm_min_o), 64'd0);
        chk("lit_rst_err", 64'(err_o), 64'd0);
        #1 rstn_i = 1'b1;
        idle(1);
        chk("lit_rst_ready", 64'(cfg_ready_o), 64'd1);

        // Back-pressure while a commit is pending
        send_byte(8'hA7);
        chk("lit_bp_pend", 64'(commit_pending_o), 64'd1);
        fork
            send_byte(8'hA6);
            begin
                idle(4);
                chk("lit_bp_ready_low", 64'(cfg_ready_o), 64'd0);
                tick();
            end
        join
        chk("lit_bp_pend_clear", 64'(commit_pending_o), 64'd0);
        send_byte(8'h77);
        send_byte(8'hA7);
        tick();
        chk("lit_bp_min", 64'(pwm_min_o), 64'h77);

        // Bad header
        send_byte(8'h5A);
        chk("lit_bad_err", 64'(err_o), 64'd1);
        chk("lit_bad_pend", 64'(commit_pending_o), 64'd0);
        send_frame(6, 32'h55);
        send_byte(8'hA7);
        tick();
        chk("lit_bad_min", 64'(pwm_min_o), 64'h55);
        chk("lit_bad_err_clear", 64'(err_o), 64'd0);

        // Timeout boundary: 998 idle cycles no error, 1000 error
        send_byte(8'hA1);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(TO - 2);
        chk("lit_to_not_yet", 64'(err_o), 64'd0);
        idle(3);
        chk("lit_to_err", 64'(err_o), 64'd1);
        send_byte(8'hA7);
        tick();
        chk("lit_to_a1", 64'($unsigned(a1_o)), 64'd0);

        // Gaps of 999 idle cycles stay inside the limit
        send_frame(2, 32'hDEAD_BEEF, TO - 1);
        send_byte(8'hA7);
        tick();
        chk("lit_gap_b0", 64'($unsigned(b0_o)), 64'hDEAD_BEEF);
        chk("lit_gap_err", 64'(err_o), 64'd0);

        // Commit accepted on a tick applies only on the next tick
        send_frame(3, 32'h0102_0304);
        send_byte(8'hA7, 0, 1'b1);
        chk("lit_co_updated", 64'(updated_o), 64'd0);
        chk("lit_co_pend", 64'(commit_pending_o), 64'd1);
        chk("lit_co_b1_old", 64'($unsigned(b1_o)), 64'd0);
        idle(2);
        tick();
        chk("lit_co_b1", 64'($unsigned(b1_o)), 64'h0102_0304);
        chk("lit_co_updated_hi", 64'(updated_o), 64'd1);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            int gp;
            r  = $urandom_range(0, 99);
            gp = ($urandom_range(0, 59) == 0) ? (TO - 1 + $urandom_range(0, 1)) : $urandom_range(0, 2);
            if (m_pend) begin
                idle($urandom_range(0, 3));
                tick();
            end else if (r < 45) begin
                send_frame($urandom_range(0, 6), $urandom, gp);
            end else if (r < 60) begin
                send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
            end else if (r < 75) begin
                send_byte({4'hA, 1'($urandom_range(0, 1)), 3'd7}, 0, 1'($urandom_range(0, 1)));
            end else if (r < 90) begin
                tick();
            end else begin
                idle($urandom_range(1, 5));
            end
        end

        idle(3);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
